// File: rtl/systolic_host_port_pkg.sv
// Shared types for the systolic host port.
// State encoding, array size limit and job-length helper.
package systolic_host_port_pkg;

  localparam int MAX_N = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    KICK,
    WAIT_DONE,
    RD_ADDR,
    RD_DATA,
    RD_HOLD
  } hp_state_t;

  function automatic logic [7:0] job_len(input logic [3:0] dim);
    return {4'd0, dim} * {4'd0, dim};
  endfunction

endpackage

// File: rtl/systolic_host_port_if.sv
// Host-side word streams: A/B words in, C words out.
// host drives in_valid/in_data/out_ready; port answers.
interface systolic_host_port_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport host (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport port (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/systolic_host_port.sv
// Host end of the systolic memory path: loads A and B,
// kicks the controller, then streams C back to the host.
module systolic_host_port
  import systolic_host_port_pkg::*;
#(
  parameter int N     = MAX_N,
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [3:0]       n,
  input  logic [AW-1:0]    addr_A,
  input  logic [AW-1:0]    addr_B,
  input  logic [AW-1:0]    addr_C,
  systolic_host_port_if.port hs,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wren,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             new_data,
  input  logic             done,
  output logic             busy,
  output logic             error,
  output hp_state_t        hp_state
);

  localparam logic [3:0] NMAX = 4'(N);

  hp_state_t        state, nstate;
  logic [7:0]       idx, len_q;
  logic [AW-1:0]    a_q, b_q, c_q;
  logic [WIDTH-1:0] od_q;
  logic             err_q;

  logic legal, loading, acc, last;

  assign legal   = (n != 4'd0) && (n <= NMAX);
  assign loading = (state == LOAD_A) || (state == LOAD_B);
  assign acc     = loading && hs.in_valid;
  assign last    = (idx + 8'd1) == len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:      if (load_start && legal) nstate = LOAD_A;
      LOAD_A:    if (acc && last) nstate = LOAD_B;
      LOAD_B:    if (acc && last) nstate = KICK;
      KICK:      nstate = WAIT_DONE;
      WAIT_DONE: if (done) nstate = RD_ADDR;
      RD_ADDR:   nstate = RD_DATA;
      RD_DATA:   nstate = RD_HOLD;
      RD_HOLD:   if (hs.out_ready) nstate = last ? IDLE : RD_ADDR;
      default:   nstate = IDLE;
    endcase
  end

  always_comb begin
    hs.in_ready = 1'b0;
    mem_wren    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    new_data    = 1'b0;
    unique case (state)
      LOAD_A, LOAD_B: begin
        hs.in_ready = 1'b1;
        mem_addr    = ((state == LOAD_A) ? a_q : b_q) + AW'(idx);
        if (hs.in_valid) begin
          mem_wren  = 1'b1;
          mem_wdata = hs.in_data;
        end
      end
      KICK:             new_data = 1'b1;
      RD_ADDR, RD_DATA: mem_addr = c_q + AW'(idx);
      default: ;
    endcase
  end

  // config, index counter, sticky error and C output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      len_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      od_q  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (load_start) begin
          if (legal) begin
            len_q <= job_len(n);
            a_q   <= addr_A;
            b_q   <= addr_B;
            c_q   <= addr_C;
            idx   <= '0;
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        LOAD_A, LOAD_B: if (acc) idx <= last ? '0 : idx + 8'd1;
        WAIT_DONE:      if (done) idx <= '0;
        RD_DATA:        od_q <= mem_rdata;
        RD_HOLD:        if (hs.out_ready) idx <= last ? '0 : idx + 8'd1;
        default: ;
      endcase
    end
  end

  assign hs.out_valid = (state == RD_HOLD);
  assign hs.out_data  = od_q;
  assign busy         = (state != IDLE);
  assign error        = err_q;
  assign hp_state     = state;

endmodule

// File: tb/tb_systolic_host_port.sv
// Directed and random jobs against a queue-based model of
// host writes, kick pulses and the C read-back stream.
module tb_systolic_host_port;
  import systolic_host_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic [3:0]  n = '0;
  logic [11:0] addr_A = '0, addr_B = '0, addr_C = '0;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_wren, new_data, busy, error;
  logic        done = 1'b0;
  hp_state_t   hp_state;

  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [15:0] mem [4096];
  logic [27:0] wlog [$];
  logic [15:0] olog [$];
  int          kicks = 0;
  int          total = 0;
  int          bad = 0;

  logic [15:0] din [$];
  logic [15:0] cdat [$];

  always #5 clk = ~clk;

  systolic_host_port_if #(.WIDTH(16)) hs ();

  systolic_host_port #(.N(4), .WIDTH(16), .AW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .n         (n),
    .addr_A    (addr_A),
    .addr_B    (addr_B),
    .addr_C    (addr_C),
    .hs        (hs),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata),
    .new_data  (new_data),
    .done      (done),
    .busy      (busy),
    .error     (error),
    .hp_state  (hp_state)
  );

  // memory with one-cycle read latency; pre_en is the stub controller
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (new_data) kicks <= kicks + 1;
    if (hs.out_valid && hs.out_ready) olog.push_back(hs.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int nn, input logic [11:0] a,
                       input logic [11:0] b, input logic [11:0] c);
    @(negedge clk);
    n = 4'(nn); addr_A = a; addr_B = b; addr_C = c;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic feed(input int cnt, input bit gaps, output int got);
    int cyc = 0;
    logic acc;
    got = 0;
    while (got < cnt && cyc < 2000) begin
      hs.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      hs.in_data  = din[got];
      #1 acc = hs.in_valid && hs.in_ready;
      @(negedge clk);
      if (acc) got++;
      cyc++;
    end
  endtask

  task automatic run_job(input int nn, input logic [11:0] a,
                         input logic [11:0] b, input logic [11:0] c,
                         input bit rnd, input int stall_k,
                         input int stall_len);
    int L = nn * nn;
    int w0 = wlog.size();
    int o0 = olog.size();
    int k0 = kicks;
    int got, cyc, stall;
    logic [11:0] ea;
    start(nn, a, b, c);
    check("start_busy", busy, 1);
    check("start_err", error, 0);
    feed(2 * L, rnd, got);
    hs.in_valid = 1'b0;
    check("load_cnt", got, 2 * L);
    repeat (3) @(negedge clk);
    check("wait_state", hp_state, WAIT_DONE);
    check("wait_busy", busy, 1);
    check("kick_cnt", kicks - k0, 1);
    check("wr_cnt", wlog.size() - w0, 2 * L);
    for (int k = 0; k < 2 * L && w0 + k < wlog.size(); k++) begin
      ea = (k < L) ? 12'((int'(a) + k) % 4096)
                   : 12'((int'(b) + k - L) % 4096);
      check("wr_word", wlog[w0 + k], {ea, din[k]});
    end
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_addr = 12'((int'(c) + k) % 4096);
      pre_data = cdat[k];
    end
    @(negedge clk);
    pre_en = 1'b0;
    check("wait_hold", hp_state, WAIT_DONE);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cyc = 0;
    stall = 0;
    while (olog.size() - o0 < L && cyc < 4000) begin
      got = olog.size() - o0;
      if (got == stall_k && stall < stall_len &&
          (stall > 0 || hs.out_valid)) begin
        hs.out_ready = 1'b0;
        check("stall_valid", hs.out_valid, 1);
        check("stall_data", hs.out_data, cdat[stall_k]);
        stall++;
      end else begin
        hs.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    hs.out_ready = 1'b0;
    check("rd_cnt", olog.size() - o0, L);
    for (int k = 0; k < L && o0 + k < olog.size(); k++)
      check("rd_word", olog[o0 + k], cdat[k]);
    check("end_busy", busy, 0);
    check("end_state", hp_state, IDLE);
    check("end_kicks", kicks - k0, 1);
  endtask

  initial begin
    int w0, k0, nn, got;
    hs.in_valid = 1'b0;
    hs.in_data = '0;
    hs.out_ready = 1'b0;
    #1;
    check("rst_state", hp_state, IDLE);
    check("rst_outs", {hs.in_ready, hs.out_valid, mem_wren,
                       new_data, busy, error}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_odata", hs.out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    din = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    cdat = {16'd19, 16'd22, 16'd43, 16'd50};
    run_job(2, 12'd0, 12'd16, 12'd32, 1'b0, 1, 10);

    w0 = wlog.size();
    start(0, 12'd0, 12'd0, 12'd0);
    check("n0_err", error, 1);
    check("n0_state", hp_state, IDLE);
    start(5, 12'd0, 12'd0, 12'd0);
    check("n5_err", error, 1);
    check("n5_state", hp_state, IDLE);
    check("bad_n_nowr", wlog.size() - w0, 0);
    din = {16'h8001, 16'h7fff};
    cdat = {16'hbeef};
    run_job(1, 12'd300, 12'd301, 12'd302, 1'b0, -1, 0);

    din = {16'd11, 16'd12, 16'd13, 16'd14,
           16'd21, 16'd22, 16'd23, 16'd24};
    cdat = {16'hffff, 16'h8000, 16'h0001, 16'h7fff};
    run_job(2, 12'd4094, 12'd4093, 12'd4095, 1'b0, -1, 0);

    // reset between clock edges in the middle of LOAD_B
    din = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    k0 = kicks;
    start(2, 12'd100, 12'd200, 12'd300);
    feed(6, 1'b0, got);
    check("mid_state", hp_state, LOAD_B);
    #2 rst = 1'b0;
    #1;
    check("ar_state", hp_state, IDLE);
    check("ar_outs", {hs.in_ready, hs.out_valid, mem_wren,
                      new_data, busy, error}, 0);
    check("ar_addr", {mem_addr, mem_wdata}, 0);
    repeat (3) @(negedge clk);
    hs.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_nokick", kicks - k0, 0);
    check("ar_idle", hp_state, IDLE);

    for (int j = 0; j < 6; j++) begin
      nn = $urandom_range(1, 4);
      din.delete();
      cdat.delete();
      for (int k = 0; k < 2 * nn * nn; k++) din.push_back(16'($urandom));
      for (int k = 0; k < nn * nn; k++) cdat.push_back(16'($urandom));
      run_job(nn, 12'($urandom), 12'($urandom), 12'($urandom),
              1'b1, $urandom_range(0, nn * nn - 1), 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
